div32: RTL and testbench

Sequential unsigned restoring divider: WIDTH-bit dividend / WIDTH-bit divisor → quotient and remainder, one quotient bit per clock. It is the inverse datapath companion to the team's sequential shift-add multiplier and uses the same start/finish handshake. The ALU/MDU wrapper issues divide operations here and collects the results when `finish` is asserted.

---
 rtl/div32.sv | 124 ++++++++++++
 tb/tb_div32.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div32.sv
`default_nettype none
// ============================================================================
// Module   : div32
// Brief    : Sequential unsigned restoring divider, one quotient bit per clock,
//            with start/finish handshake and divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             finish,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_div;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_dbz;

    logic                 w_accept;
    logic                 w_dz;
    logic                 w_last;
    logic [WIDTH:0]       w_hi;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_dz     = (divisor == '0);
    assign w_last   = (r_cnt == c_LAST);

    // Shifted partial remainder keeps the bit shifted out, so the compare
    // cannot overflow; the subtraction result always fits in WIDTH bits.
    assign w_hi      = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge      = (w_hi >= {1'b0, r_div});
    assign w_diff    = w_hi[WIDTH-1:0] - r_div;
    assign w_acc_nxt = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                            : {r_acc[2*WIDTH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = w_dz ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            if (w_dz) begin
                r_quot <= '1;
                r_rem  <= dividend;
                r_dbz  <= 1'b1;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, dividend};
                r_div  <= divisor;
                r_cnt  <= '0;
                r_dbz  <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + c_ONE;
            if (w_last) begin
                r_quot <= w_acc_nxt[WIDTH-1:0];
                r_rem  <= w_acc_nxt[2*WIDTH-1:WIDTH];
                r_dbz  <= 1'b0;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign busy        = (r_state == S_RUN);
    assign finish      = (r_state == S_DONE);
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div32.sv
`default_nettype none
// ============================================================================
// Module   : tb_div32
// Brief    : Scoreboard-based self-checking bench for div32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        finish;
    logic        div_by_zero;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div32 #(.WIDTH(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .finish     (finish),
        .div_by_zero(div_by_zero)
    );

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drives a one-cycle start and leaves the bench at the negedge after acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Counts edges after acceptance until finish; bad counts busy profile errors.
    task automatic wait_done(input int lat0, output int lat, output int bad);
        lat = lat0;
        bad = 0;
        while (!finish && lat < 100) begin
            if (busy !== 1'b1) bad++;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({quotient, remainder, busy, finish, div_by_zero} !== 67'd0) begin
            n_miss++;
            $display("FAIL reset_outputs got q=%h r=%h busy=%b fin=%b dbz=%b exp all 0",
                     quotient, remainder, busy, finish, div_by_zero);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, finish} !== 2'b00) begin
            n_miss++;
            $display("FAIL reset_idle got busy=%b fin=%b exp 0 0", busy, finish);
        end
    endtask

    task automatic test_basic();
        int lat, bad;
        exp_t e;
        issue(32'd100, 32'd7);
        wait_done(0, lat, bad);
        e = sb.pop_front();
        n_vec++;
        if (lat != 32 || bad != 0) begin
            n_miss++;
            $display("FAIL basic_latency got lat=%0d bad=%0d exp lat=32 bad=0", lat, bad);
        end
        n_vec++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz} || e.q !== 32'd14) begin
            n_miss++;
            $display("FAIL basic_result got q=%0d r=%0d dbz=%b exp q=14 r=2 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (finish !== 1'b1 || quotient !== 32'd14) begin
            n_miss++;
            $display("FAIL basic_hold got fin=%b q=%0d exp fin=1 q=14", finish, quotient);
        end
    endtask

    task automatic test_edges();
        logic [31:0] as [3];
        logic [31:0] bs [3];
        int lat, bad;
        exp_t e;
        as[0] = 32'hFFFF_FFFF; bs[0] = 32'd1;
        as[1] = 32'hFFFF_FFFF; bs[1] = 32'hFFFF_FFFF;
        as[2] = 32'd3;         bs[2] = 32'd10;
        for (int i = 0; i < 3; i++) begin
            issue(as[i], bs[i]);
            n_vec++;
            if (i == 0 && (quotient !== 32'd14 || remainder !== 32'd2 || finish !== 1'b0)) begin
                n_miss++;
                $display("FAIL edge_prev_hold got q=%0d r=%0d fin=%b exp q=14 r=2 fin=0",
                         quotient, remainder, finish);
            end
            wait_done(0, lat, bad);
            e = sb.pop_front();
            n_vec++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz} || lat != 32 || bad != 0) begin
                n_miss++;
                $display("FAIL edge_%0d got q=%h r=%h dbz=%b lat=%0d exp q=%h r=%h dbz=%b lat=32",
                         i, quotient, remainder, div_by_zero, lat, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bad;
        exp_t e;
        issue(32'd5, 32'd0);
        wait_done(0, lat, bad);
        e = sb.pop_front();
        n_vec++;
        if (lat != 0 || bad != 0) begin
            n_miss++;
            $display("FAIL dz_latency got lat=%0d bad=%0d exp lat=0 bad=0", lat, bad);
        end
        n_vec++;
        if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 32'd5, 1'b1}) begin
            n_miss++;
            $display("FAIL dz_result got q=%h r=%h dbz=%b exp q=ffffffff r=5 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        issue(32'd9, 32'd3);
        n_vec++;
        if ({div_by_zero, finish, busy} !== 3'b001) begin
            n_miss++;
            $display("FAIL dz_clear got dbz=%b fin=%b busy=%b exp 0 0 1",
                     div_by_zero, finish, busy);
        end
        wait_done(0, lat, bad);
        e = sb.pop_front();
        n_vec++;
        if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
            n_miss++;
            $display("FAIL dz_after got q=%0d r=%0d exp q=%0d r=%0d", quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_start_ignored();
        int lat, bad;
        exp_t e;
        issue(32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, lat, bad);
        e = sb.pop_front();
        n_vec++;
        if ({quotient, remainder} !== {32'd333, 32'd1} || {quotient, remainder} !== {e.q, e.r}
            || lat != 32 || bad != 0) begin
            n_miss++;
            $display("FAIL ignore_start got q=%0d r=%0d lat=%0d bad=%0d exp q=333 r=1 lat=32 bad=0",
                     quotient, remainder, lat, bad);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bad, stale;
        exp_t e;
        issue(32'h8000_0000, 32'd2);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        n_vec++;
        if ({quotient, remainder, busy, finish, div_by_zero} !== 67'd0) begin
            n_miss++;
            $display("FAIL abort_outputs got q=%h r=%h busy=%b fin=%b dbz=%b exp all 0",
                     quotient, remainder, busy, finish, div_by_zero);
        end
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (finish !== 1'b0 || busy !== 1'b0) stale++;
        end
        n_vec++;
        if (stale != 0) begin
            n_miss++;
            $display("FAIL abort_stale got %0d active cycles exp 0", stale);
        end
        issue(32'd9, 32'd4);
        wait_done(0, lat, bad);
        e = sb.pop_front();
        n_vec++;
        if ({quotient, remainder} !== {32'd2, 32'd1} || {quotient, remainder} !== {e.q, e.r}
            || lat != 32 || bad != 0) begin
            n_miss++;
            $display("FAIL abort_recover got q=%0d r=%0d lat=%0d exp q=2 r=1 lat=32",
                     quotient, remainder, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] as [3];
        logic [31:0] bs [3];
        int lat, bad;
        exp_t e;
        as[0] = 32'd77;       bs[0] = 32'd5;
        as[1] = 32'h1234_5678; bs[1] = 32'h0000_0101;
        as[2] = 32'd6;        bs[2] = 32'd6;
        @(negedge clk);
        dividend = as[0]; divisor = bs[0]; start = 1'b1;
        sb.push_back(model(as[0], bs[0]));
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                dividend = as[k+1]; divisor = bs[k+1];
                sb.push_back(model(as[k+1], bs[k+1]));
            end else begin
                start = 1'b0;
            end
            wait_done(0, lat, bad);
            e = sb.pop_front();
            n_vec++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz} || lat != 32 || bad != 0) begin
                n_miss++;
                $display("FAIL b2b_%0d got q=%h r=%h lat=%0d bad=%0d exp q=%h r=%h lat=32",
                         k, quotient, remainder, lat, bad, e.q, e.r);
            end
            if (k < 2) begin
                @(negedge clk);
                n_vec++;
                if ({finish, busy} !== 2'b01) begin
                    n_miss++;
                    $display("FAIL b2b_restart_%0d got fin=%b busy=%b exp 0 1", k, finish, busy);
                end
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a, b;
        logic [63:0] recon;
        int lat, bad;
        exp_t e;
        for (int i = 0; i < 1000; i++) begin
            a = pick();
            b = pick();
            issue(a, b);
            wait_done(0, lat, bad);
            e = sb.pop_front();
            n_vec++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
                n_miss++;
                $display("FAIL rand_result a=%h b=%h got q=%h r=%h dbz=%b exp q=%h r=%h dbz=%b",
                         a, b, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
            end
            n_vec++;
            if (lat != ((b == 32'd0) ? 0 : 32) || bad != 0) begin
                n_miss++;
                $display("FAIL rand_latency a=%h b=%h got lat=%0d bad=%0d exp lat=%0d bad=0",
                         a, b, lat, bad, (b == 32'd0) ? 0 : 32);
            end
            if (b != 32'd0) begin
                recon = 64'(quotient) * 64'(b) + 64'(remainder);
                n_vec++;
                if (recon !== 64'(a) || !(remainder < b)) begin
                    n_miss++;
                    $display("FAIL rand_identity a=%h b=%h got q*b+r=%h r=%h exp %h with r<b",
                             a, b, recon, remainder, a);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
